step_pos_tracker: RTL and testbench

Receive-side decoder for the interpolator's step-pulse interface. It synchronises the four direction pulses (X_acc, X_dec, Y_acc, Y_dec) into the sys_clk domain and edge-detects them. It accumulates signed X/Y positions and a step count, and flags arrival at a latched target endpoint or a protocol fault. It sits at the motor-driver end of the interpolator path and provides closed-loop checking of every line/arc command.

---
 rtl/step_pkg.sv | 34 +++
 rtl/step_axis_decoder.sv | 73 +++++++
 rtl/step_pos_tracker.sv | 137 +++++++++++++
 tb/tb_step_pos_tracker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// Shared types and helpers for the step-pulse position tracker.
package step_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    DONE  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    FLT_NONE  = 2'b00,
    FLT_BOTH  = 2'b01,
    FLT_OVF   = 2'b10,
    FLT_STALL = 2'b11
  } fault_e;

  // Saturation limits of a w-bit two's complement position.
  function automatic logic signed [31:0] pos_max(input int unsigned w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  function automatic logic signed [31:0] pos_min(input int unsigned w);
    return -(32'sd1 <<< (w - 1));
  endfunction

  // When several faults land in one cycle the lowest code is recorded.
  function automatic fault_e fault_sel(input logic both, input logic ovf, input logic stall);
    if (both)       return FLT_BOTH;
    else if (ovf)   return FLT_OVF;
    else if (stall) return FLT_STALL;
    else            return FLT_NONE;
  endfunction

endpackage

// File: rtl/step_axis_decoder.sv
// One axis: pulse synchronisers, rising-edge detect and saturating signed position.
module step_axis_decoder
  import step_pkg::*;
#(
  parameter int unsigned W           = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic                acc_i,
  input  logic                dec_i,
  output logic signed [W-1:0] pos_o,
  output logic                step_o,
  output logic                both_o,
  output logic                ovf_o
);

  localparam logic signed [W-1:0] POS_MAX = W'(pos_max(W));
  localparam logic signed [W-1:0] POS_MIN = W'(pos_min(W));
  localparam logic signed [W-1:0] ONE     = W'(1);

  logic [SYNC_STAGES-1:0] acc_sync_q, dec_sync_q;
  logic                   acc_prev_q, dec_prev_q;
  logic signed [W-1:0]    pos_q, pos_d;
  logic                   acc_rise, dec_rise;

  // Edge history keeps running while disabled so stale levels never fire later.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_sync_q <= '0;
      dec_sync_q <= '0;
      acc_prev_q <= 1'b0;
      dec_prev_q <= 1'b0;
      pos_q      <= '0;
    end else begin
      acc_sync_q <= {acc_sync_q[SYNC_STAGES-2:0], acc_i};
      dec_sync_q <= {dec_sync_q[SYNC_STAGES-2:0], dec_i};
      acc_prev_q <= acc_sync_q[SYNC_STAGES-1];
      dec_prev_q <= dec_sync_q[SYNC_STAGES-1];
      pos_q      <= pos_d;
    end
  end

  assign acc_rise = acc_sync_q[SYNC_STAGES-1] & ~acc_prev_q;
  assign dec_rise = dec_sync_q[SYNC_STAGES-1] & ~dec_prev_q;

  always_comb begin
    pos_d  = pos_q;
    step_o = 1'b0;
    both_o = 1'b0;
    ovf_o  = 1'b0;
    if (clr_i) begin
      pos_d = '0;
    end else if (en_i) begin
      if (acc_rise && dec_rise) begin
        both_o = 1'b1;
      end else if (acc_rise) begin
        step_o = 1'b1;
        if (pos_q == POS_MAX) ovf_o = 1'b1;
        else                  pos_d = pos_q + ONE;
      end else if (dec_rise) begin
        step_o = 1'b1;
        if (pos_q == POS_MIN) ovf_o = 1'b1;
        else                  pos_d = pos_q - ONE;
      end
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/step_pos_tracker.sv
// Receive-side step decoder: tracks X/Y position and step count, flags arrival and faults.
module step_pos_tracker
  import step_pkg::*;
#(
  parameter int unsigned W           = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1000000
) (
  input  logic                sys_clk,
  input  logic                sys_rst_l,
  input  logic                X_acc,
  input  logic                X_dec,
  input  logic                Y_acc,
  input  logic                Y_dec,
  input  logic signed [W-1:0] Xe,
  input  logic signed [W-1:0] Ye,
  input  logic                start_H,
  output logic signed [W-1:0] X_pos,
  output logic signed [W-1:0] Y_pos,
  output logic [W:0]          step_cnt,
  output logic                arrive_H,
  output logic                fault_H,
  output logic [1:0]          fault_code
);

  localparam int unsigned CW  = W + 1;
  localparam int unsigned TCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic signed [W-1:0] xe_q, xe_d, ye_q, ye_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TCW-1:0]      tmo_q, tmo_d;
  logic                arrive_q, arrive_d;
  logic                fault_q, fault_d;
  fault_e              code_q, code_d;
  fault_e              cand;

  logic x_step, x_both, x_ovf, y_step, y_both, y_ovf;
  logic any_edge, stall, overshoot, track_en;

  assign track_en = (state_q != IDLE);

  step_axis_decoder #(.W(W), .SYNC_STAGES(SYNC_STAGES)) u_x (
    .clk_i (sys_clk), .rst_ni (sys_rst_l), .clr_i (start_H), .en_i (track_en),
    .acc_i (X_acc), .dec_i (X_dec), .pos_o (X_pos),
    .step_o (x_step), .both_o (x_both), .ovf_o (x_ovf)
  );

  step_axis_decoder #(.W(W), .SYNC_STAGES(SYNC_STAGES)) u_y (
    .clk_i (sys_clk), .rst_ni (sys_rst_l), .clr_i (start_H), .en_i (track_en),
    .acc_i (Y_acc), .dec_i (Y_dec), .pos_o (Y_pos),
    .step_o (y_step), .both_o (y_both), .ovf_o (y_ovf)
  );

  assign any_edge = x_step | x_both | y_step | y_both;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      state_q  <= IDLE;
      xe_q     <= '0;
      ye_q     <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      arrive_q <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= FLT_NONE;
    end else begin
      state_q  <= state_d;
      xe_q     <= xe_d;
      ye_q     <= ye_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      arrive_q <= arrive_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    xe_d      = xe_q;
    ye_d      = ye_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    arrive_d  = arrive_q;
    fault_d   = fault_q;
    code_d    = code_q;
    stall     = 1'b0;
    overshoot = 1'b0;
    cand      = FLT_NONE;
    if (start_H) begin
      state_d  = TRACK;
      xe_d     = Xe;
      ye_d     = Ye;
      cnt_d    = '0;
      tmo_d    = '0;
      arrive_d = 1'b0;
      fault_d  = 1'b0;
      code_d   = FLT_NONE;
    end else begin
      cnt_d = cnt_q + CW'(x_step) + CW'(y_step);
      case (state_q)
        TRACK: begin
          // Counter parks at TIMEOUT so the stall fault fires exactly once.
          if (any_edge) begin
            tmo_d = '0;
          end else if (TIMEOUT != 0 && tmo_q != TCW'(TIMEOUT)) begin
            tmo_d = tmo_q + TCW'(1);
            stall = (tmo_q == TCW'(TIMEOUT - 1));
          end
          if (X_pos == xe_q && Y_pos == ye_q) begin
            state_d  = DONE;
            arrive_d = 1'b1;
          end
        end
        DONE: begin
          if (any_edge) begin
            arrive_d  = 1'b0;
            overshoot = 1'b1;
          end
        end
        default: ;
      endcase
      cand = fault_sel(x_both | y_both, x_ovf | y_ovf | overshoot, stall);
      if (!fault_q && cand != FLT_NONE) begin
        fault_d = 1'b1;
        code_d  = cand;
      end
    end
  end

  assign step_cnt   = cnt_q;
  assign arrive_H   = arrive_q;
  assign fault_H    = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_step_pos_tracker.sv
// Drives two trackers (W=16/TIMEOUT=20 and W=4/no timeout) with shared stimulus against a step-event model.
module tb_step_pos_tracker;

  localparam int S = 2;
  localparam logic [3:0] XA = 4'b0001, XD = 4'b0010, YA = 4'b0100, YD = 4'b1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_l = 1'b0, start = 1'b0;
  logic xa = 1'b0, xd = 1'b0, ya = 1'b0, yd = 1'b0;
  logic signed [15:0] xe = '0, ye = '0;
  logic signed [3:0]  xe4, ye4;
  assign xe4 = xe[3:0];
  assign ye4 = ye[3:0];

  logic signed [15:0] xpa, ypa;
  logic [16:0]        sca;
  logic               ara, fha;
  logic [1:0]         fca;
  logic signed [3:0]  xpb, ypb;
  logic [4:0]         scb;
  logic               arb, fhb;
  logic [1:0]         fcb;

  step_pos_tracker #(.W(16), .SYNC_STAGES(S), .TIMEOUT(20)) dut_a (
    .sys_clk(clk), .sys_rst_l(rst_l), .X_acc(xa), .X_dec(xd), .Y_acc(ya), .Y_dec(yd),
    .Xe(xe), .Ye(ye), .start_H(start), .X_pos(xpa), .Y_pos(ypa), .step_cnt(sca),
    .arrive_H(ara), .fault_H(fha), .fault_code(fca));

  step_pos_tracker #(.W(4), .SYNC_STAGES(S), .TIMEOUT(0)) dut_b (
    .sys_clk(clk), .sys_rst_l(rst_l), .X_acc(xa), .X_dec(xd), .Y_acc(ya), .Y_dec(yd),
    .Xe(xe4), .Ye(ye4), .start_H(start), .X_pos(xpb), .Y_pos(ypb), .step_cnt(scb),
    .arrive_H(arb), .fault_H(fhb), .fault_code(fcb));

  int compared = 0, mismatched = 0;

  // Reference model: per-DUT position/step bookkeeping; mode 0 idle, 1 tracking, 2 arrived.
  int mw[2]  = '{16, 4};
  int mto[2] = '{20, 0};
  int mx[2], my[2], mtx[2], mty[2], mcnt[2], mtmo[2], mmode[2], marr[2], mflt[2], mcode[2];
  logic [3:0] hist [0:S+1];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int d);
    mx[d] = 0; my[d] = 0; mtx[d] = 0; mty[d] = 0; mcnt[d] = 0; mtmo[d] = 0;
    mmode[d] = 0; marr[d] = 0; mflt[d] = 0; mcode[d] = 0;
  endtask

  task automatic model_edge();
    logic [3:0] rise;
    int lim, ox, oy, code;
    bit both, ovf, stall, any;
    if (!rst_l) begin
      for (int d = 0; d < 2; d++) model_clear(d);
      for (int i = 0; i <= S + 1; i++) hist[i] = '0;
      return;
    end
    for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {yd, ya, xd, xa};
    // A level first sampled high S edges ago becomes a step now.
    rise = hist[S] & ~hist[S+1];
    for (int d = 0; d < 2; d++) begin
      lim = 1 << (mw[d] - 1);
      if (start) begin
        model_clear(d);
        mmode[d] = 1;
        mtx[d] = (d == 0) ? int'(xe) : int'(xe4);
        mty[d] = (d == 0) ? int'(ye) : int'(ye4);
      end else if (mmode[d] != 0) begin
        ox = mx[d]; oy = my[d];
        both = 0; ovf = 0; stall = 0;
        any = (rise != 4'b0000);
        if (rise[0] && rise[1]) both = 1;
        else if (rise[0]) begin mcnt[d]++; if (mx[d] == lim - 1) ovf = 1; else mx[d]++; end
        else if (rise[1]) begin mcnt[d]++; if (mx[d] == -lim) ovf = 1; else mx[d]--; end
        if (rise[2] && rise[3]) both = 1;
        else if (rise[2]) begin mcnt[d]++; if (my[d] == lim - 1) ovf = 1; else my[d]++; end
        else if (rise[3]) begin mcnt[d]++; if (my[d] == -lim) ovf = 1; else my[d]--; end
        if (mmode[d] == 1) begin
          if (any) mtmo[d] = 0;
          else if (mtmo[d] < mto[d]) begin
            if (mtmo[d] == mto[d] - 1) stall = 1;
            mtmo[d]++;
          end
          if (ox == mtx[d] && oy == mty[d]) begin mmode[d] = 2; marr[d] = 1; end
        end else if (any) begin
          marr[d] = 0; ovf = 1;
        end
        code = both ? 1 : ovf ? 2 : stall ? 3 : 0;
        if (mflt[d] == 0 && code != 0) begin mflt[d] = 1; mcode[d] = code; end
      end
    end
  endtask

  task automatic check_dut(input int d, input logic signed [31:0] xp, input logic signed [31:0] yp,
                           input logic signed [31:0] sc, input logic signed [31:0] ar,
                           input logic signed [31:0] fh, input logic signed [31:0] fc);
    chk($sformatf("d%0d_x_pos", d), xp, mx[d]);
    chk($sformatf("d%0d_y_pos", d), yp, my[d]);
    chk($sformatf("d%0d_step_cnt", d), sc, mcnt[d] % (1 << (mw[d] + 1)));
    chk($sformatf("d%0d_arrive", d), ar, marr[d]);
    chk($sformatf("d%0d_fault_H", d), fh, mflt[d]);
    chk($sformatf("d%0d_fault_code", d), fc, mcode[d]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_dut(0, xpa, ypa, sca, ara, fha, fca);
    check_dut(1, xpb, ypb, scb, arb, fhb, fcb);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_lines(input logic [3:0] m);
    {yd, ya, xd, xa} = m;
  endtask

  task automatic cmd(input int x, input int y);
    xe = 16'(x); ye = 16'(y);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] m, input int hi, input int lo);
    set_lines(m);
    idle(hi);
    set_lines(4'b0000);
    idle(lo);
  endtask

  initial begin
    logic [3:0] m;
    idle(3);
    rst_l = 1'b1;
    chk("rst_x_pos", xpa, 0);
    chk("rst_step_cnt", sca, 0);
    chk("rst_fault_code", fca, 0);

    // Reach (5,3) with interleaved X/Y increments.
    cmd(5, 3);
    for (int i = 0; i < 5; i++) begin
      pulse(XA, 4, 4);
      if (i < 3) pulse(YA, 4, 4);
    end
    idle(3);
    chk("tp1_x_pos", xpa, 5);
    chk("tp1_y_pos", ypa, 3);
    chk("tp1_step_cnt", sca, 8);
    chk("tp1_arrive", ara, 1);
    chk("tp1_fault_H", fha, 0);

    // Negative target, then overshoot.
    cmd(-4, 0);
    repeat (4) pulse(XD, 4, 4);
    idle(2);
    chk("tp2_x_pos", xpa, -4);
    chk("tp2_arrive", ara, 1);
    pulse(XD, 4, 4);
    chk("tp2_over_x_pos", xpa, -5);
    chk("tp2_over_arrive", ara, 0);
    chk("tp2_over_code", fca, 2);

    // Simultaneous acc+dec on X.
    cmd(2, 2);
    pulse(XA | XD, 4, 4);
    chk("tp3_x_pos", xpa, 0);
    chk("tp3_code", fca, 1);
    pulse(YA, 4, 4);
    chk("tp3_y_pos", ypa, 1);

    // Saturation on the narrow tracker.
    cmd(-8, 0);
    repeat (8) pulse(XA, 4, 4);
    chk("tp4_w4_x_pos", xpb, 7);
    chk("tp4_w4_code", fcb, 2);
    chk("tp4_w16_x_pos", xpa, 8);

    // Stall timeout, then late arrival.
    cmd(1, 0);
    idle(19);
    chk("tp5_pre_stall_code", fca, 0);
    tick();
    chk("tp5_stall_code", fca, 3);
    pulse(XA, 4, 4);
    chk("tp5_x_pos", xpa, 1);
    chk("tp5_arrive", ara, 1);
    chk("tp5_fault_H", fha, 1);
    chk("tp5_code_held", fca, 3);

    // Reset mid-track, pulses in idle ignored.
    cmd(3, 3);
    pulse(XA, 4, 4);
    pulse(YA, 4, 2);
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    chk("tp6_x_pos", xpa, 0);
    chk("tp6_step_cnt", sca, 0);
    pulse(XA, 4, 4);
    pulse(YA, 4, 4);
    chk("tp6_idle_x_pos", xpa, 0);
    chk("tp6_idle_y_pos", ypa, 0);

    // Zero target arrives right after entering tracking.
    cmd(0, 0);
    tick();
    chk("zero_target_arrive", ara, 1);

    // Start colliding with an edge drops the edge.
    set_lines(XA);
    idle(2);
    cmd(1, 0);
    idle(2);
    set_lines(4'b0000);
    idle(4);
    chk("start_wins_x_pos", xpa, 0);

    // Randomised commands and pulse trains.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
      end
      cmd($urandom_range(0, 6) - 3, $urandom_range(0, 6) - 3);
      for (int k = $urandom_range(0, 9); k > 0; k--) begin
        m = 4'b0001 << $urandom_range(0, 3);
        case ($urandom_range(0, 9))
          0: m = m | (m[0] | m[1] ? XA | XD : YA | YD);
          1, 2: m = m | (m[0] | m[1] ? ($urandom_range(0, 1) ? YA : YD) : ($urandom_range(0, 1) ? XA : XD));
          default: ;
        endcase
        pulse(m, $urandom_range(3, 5), $urandom_range(3, 6));
      end
      idle($urandom_range(0, 25));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
